// File: rtl/fetch_pc_ctrl_pkg.sv
// rtl/fetch_pc_ctrl_pkg.sv - shared widths, reset PC, NOP encoding and FSM states for fetch_pc_ctrl
package fetch_pc_ctrl_pkg;

  localparam int          WORD     = 32;
  localparam logic [31:0] PC_RST   = 32'h1C00_0000;
  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - single-outstanding icache request/response bus
interface fetch_pc_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              addr_ok;
  logic              data_ok;
  logic [ADDR_W-1:0] rdata;

  // fetch side issues requests and receives responses
  modport master (
    output req,
    output addr,
    input  addr_ok,
    input  data_ok,
    input  rdata
  );

  // icache side accepts requests and returns words
  modport slave (
    input  req,
    input  addr,
    output addr_ok,
    output data_ok,
    output rdata
  );

endinterface

// File: rtl/fetch_pc_ctrl_pc_hold_reg.sv
// rtl/fetch_pc_ctrl_pc_hold_reg.sv - fetch PC hold register with write enable
module pc_hold_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_out
);

  // PC only changes on sequential advance or an applied redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out <= RESET_PC;
    end else if (we) begin
      pc_out <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch PC sequencer, icache handshake and IF slot (optional FETCH_ALIGN_CHK_EN)
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = WORD,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              excp_valid,
  input  logic [ADDR_W-1:0] excp_target,
  input  logic              br_redirect,
  input  logic [ADDR_W-1:0] br_target,
  fetch_pc_ctrl_if.master   icache,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_inst,
  input  logic              if_ready
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic              if_excp_adef
`endif
);

  fetch_state_t state, state_nxt;

  logic [ADDR_W-1:0] pc, pc_d;
  logic              pc_we;

  logic              cancel, cancel_nxt;
  logic              pend_vld, pend_vld_nxt;
  logic [ADDR_W-1:0] pend, pend_nxt;

  logic              slot_vld, slot_vld_nxt;
  logic [ADDR_W-1:0] slot_pc, slot_pc_nxt;
  logic [ADDR_W-1:0] slot_inst, slot_inst_nxt;

  // response parked while the slot is still occupied (HOLD)
  logic [ADDR_W-1:0] buf_pc, buf_pc_nxt;
  logic [ADDR_W-1:0] buf_inst, buf_inst_nxt;

  // set when HOLD is parked on a faulting target; only a redirect leaves it
  logic              adef_stop, adef_stop_nxt;

  logic              redir;
  logic [ADDR_W-1:0] redir_sel;
  logic [ADDR_W-1:0] redir_tgt;
  logic              consume;
  logic              go;
  logic [ADDR_W-1:0] go_tgt;

  pc_hold_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_hold_reg (
    .clk    (clk),
    .rst    (rst),
    .we     (pc_we),
    .pc_in  (pc_d),
    .pc_out (pc)
  );

  // exception outranks branch; without the alignment check the low bits are dropped
  always_comb begin
    redir     = excp_valid | br_redirect;
    redir_sel = excp_valid ? excp_target : br_target;
`ifdef FETCH_ALIGN_CHK_EN
    redir_tgt = redir_sel;
`else
    redir_tgt = redir_sel & ~ADDR_W'(3);
`endif
    consume   = slot_vld & if_ready;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state, PC update, redirect/cancel bookkeeping and slot control
  always_comb begin
    state_nxt     = state;
    pc_we         = 1'b0;
    pc_d          = pc + ADDR_W'(4);
    cancel_nxt    = cancel;
    pend_vld_nxt  = pend_vld;
    pend_nxt      = pend;
    slot_vld_nxt  = slot_vld & ~consume;
    slot_pc_nxt   = slot_pc;
    slot_inst_nxt = slot_inst;
    buf_pc_nxt    = buf_pc;
    buf_inst_nxt  = buf_inst;
    adef_stop_nxt = adef_stop;
    go            = 1'b0;
    go_tgt        = redir_tgt;

    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (redir) begin
          go = 1'b1;
        end
      end

      S_REQ: begin
        // address must stay put until accepted, so a redirect is parked in pend
        if (redir) begin
          slot_vld_nxt = 1'b0;
          pend_nxt     = redir_tgt;
          pend_vld_nxt = 1'b1;
          if (icache.addr_ok) begin
            cancel_nxt = 1'b1;
            state_nxt  = S_WAIT;
          end
        end else if (icache.addr_ok) begin
          if (pend_vld) begin
            cancel_nxt = 1'b1;
          end
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redir) begin
          slot_vld_nxt = 1'b0;
          if (icache.data_ok) begin
            go = 1'b1;
          end else begin
            cancel_nxt   = 1'b1;
            pend_nxt     = redir_tgt;
            pend_vld_nxt = 1'b1;
          end
        end else if (icache.data_ok) begin
          if (cancel) begin
            go     = 1'b1;
            go_tgt = pend;
          end else begin
            pc_we = 1'b1;
            if (!slot_vld || consume) begin
              slot_vld_nxt  = 1'b1;
              slot_pc_nxt   = pc;
              slot_inst_nxt = icache.rdata;
              state_nxt     = S_REQ;
            end else begin
              buf_pc_nxt   = pc;
              buf_inst_nxt = icache.rdata;
              state_nxt    = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        if (redir) begin
          slot_vld_nxt = 1'b0;
          go           = 1'b1;
        end else if (!adef_stop && consume) begin
          slot_vld_nxt  = 1'b1;
          slot_pc_nxt   = buf_pc;
          slot_inst_nxt = buf_inst;
          state_nxt     = S_REQ;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    // apply a redirect target: either fetch from it or park on an ADEF fault
    if (go) begin
      cancel_nxt    = 1'b0;
      pend_vld_nxt  = 1'b0;
      pc_we         = 1'b1;
      pc_d          = go_tgt;
      adef_stop_nxt = 1'b0;
      state_nxt     = S_REQ;
`ifdef FETCH_ALIGN_CHK_EN
      if (go_tgt[1:0] != 2'b00) begin
        slot_vld_nxt  = 1'b1;
        slot_pc_nxt   = go_tgt;
        slot_inst_nxt = ADDR_W'(NOP_INST);
        adef_stop_nxt = 1'b1;
        state_nxt     = S_HOLD;
      end
`endif
    end
  end

  // redirect bookkeeping, IF slot and parked response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cancel    <= 1'b0;
      pend_vld  <= 1'b0;
      pend      <= '0;
      slot_vld  <= 1'b0;
      slot_pc   <= '0;
      slot_inst <= '0;
      buf_pc    <= '0;
      buf_inst  <= '0;
      adef_stop <= 1'b0;
    end else begin
      cancel    <= cancel_nxt;
      pend_vld  <= pend_vld_nxt;
      pend      <= pend_nxt;
      slot_vld  <= slot_vld_nxt;
      slot_pc   <= slot_pc_nxt;
      slot_inst <= slot_inst_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_inst  <= buf_inst_nxt;
      adef_stop <= adef_stop_nxt;
    end
  end

  assign icache.req  = (state == S_REQ);
  assign icache.addr = pc;
  assign if_valid    = slot_vld;
  assign if_pc       = slot_pc;
  assign if_inst     = slot_inst;
`ifdef FETCH_ALIGN_CHK_EN
  assign if_excp_adef = slot_vld & adef_stop;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        excp_valid;
  logic [31:0] excp_target;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
`ifdef FETCH_ALIGN_CHK_EN
  logic        if_excp_adef;
`endif

  int checks = 0;
  int errors = 0;

  fetch_pc_ctrl_if #(.ADDR_W(32)) ic ();

  fetch_pc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .excp_valid  (excp_valid),
    .excp_target (excp_target),
    .br_redirect (br_redirect),
    .br_target   (br_target),
    .icache      (ic),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_ready    (if_ready)
`ifdef FETCH_ALIGN_CHK_EN
    ,
    .if_excp_adef (if_excp_adef)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept();
    ic.addr_ok = 1'b1;
    tick();
    ic.addr_ok = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    ic.data_ok = 1'b1;
    ic.rdata   = d;
    tick();
    ic.data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    excp_valid = 1'b0; excp_target = '0;
    br_redirect = 1'b0; br_target = '0;
    if_ready = 1'b0;
    ic.addr_ok = 1'b0; ic.data_ok = 1'b0; ic.rdata = '0;

    // reset state
    tick(); tick(); tick();
    check("rst_req", {31'd0, ic.req}, 32'd0);
    check("rst_addr", ic.addr, 32'h1C00_0000);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);

    // first request one cycle after release
    rst = 1'b0;
    tick();
    check("t1_req0", {31'd0, ic.req}, 32'd1);
    check("t1_addr0", ic.addr, 32'h1C00_0000);

    // sequential fetch with immediate handshake
    if_ready = 1'b1;
    accept();
    check("t1_wait_req", {31'd0, ic.req}, 32'd0);
    respond(32'hA000_0000);
    check("t1_valid0", {31'd0, if_valid}, 32'd1);
    check("t1_pc0", if_pc, 32'h1C00_0000);
    check("t1_inst0", if_inst, 32'hA000_0000);
    check("t1_addr1", ic.addr, 32'h1C00_0004);
    accept();
    check("t1_consumed", {31'd0, if_valid}, 32'd0);
    respond(32'hA000_0001);
    check("t1_pc1", if_pc, 32'h1C00_0004);
    check("t1_inst1", if_inst, 32'hA000_0001);
    check("t1_addr2", ic.addr, 32'h1C00_0008);

    // decode stalls: second word parks, fetch stops
    if_ready = 1'b0;
    accept();
    respond(32'hA000_0002);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_req", {31'd0, ic.req}, 32'd0);
      check("t2_hold_inst", if_inst, 32'hA000_0001);
      tick();
    end
    if_ready = 1'b1;
    tick();
    check("t2_rel_valid", {31'd0, if_valid}, 32'd1);
    check("t2_rel_pc", if_pc, 32'h1C00_0008);
    check("t2_rel_inst", if_inst, 32'hA000_0002);
    check("t2_rel_req", {31'd0, ic.req}, 32'd1);
    check("t2_rel_addr", ic.addr, 32'h1C00_000C);

    // branch redirect while waiting: response dropped
    accept();
    br_redirect = 1'b1; br_target = 32'h1C00_0100;
    tick();
    br_redirect = 1'b0;
    respond(32'hA000_0003);
    check("t3_dropped", {31'd0, if_valid}, 32'd0);
    check("t3_req", {31'd0, ic.req}, 32'd1);
    check("t3_addr", ic.addr, 32'h1C00_0100);

    // exception beats branch, arriving with data_ok
    accept();
    excp_valid = 1'b1; excp_target = 32'h1C00_8000;
    br_redirect = 1'b1; br_target = 32'h1C00_0200;
    ic.data_ok = 1'b1; ic.rdata = 32'hA000_0004;
    tick();
    excp_valid = 1'b0; br_redirect = 1'b0; ic.data_ok = 1'b0;
    check("t4_dropped", {31'd0, if_valid}, 32'd0);
    check("t4_addr", ic.addr, 32'h1C00_8000);

    // redirect while request is not yet accepted: address held
    tick();
    br_redirect = 1'b1; br_target = 32'h1C00_0300;
    tick();
    br_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_addr_held", ic.addr, 32'h1C00_8000);
      check("t5_req_held", {31'd0, ic.req}, 32'd1);
      tick();
    end
    accept();
    respond(32'hA000_0005);
    check("t5_dropped", {31'd0, if_valid}, 32'd0);
    check("t5_addr", ic.addr, 32'h1C00_0300);

    // consume and redirect in the same cycle: slot cleared
    accept();
    respond(32'hA000_0006);
    check("t7_valid", {31'd0, if_valid}, 32'd1);
    br_redirect = 1'b1; br_target = 32'h1C00_0400;
    tick();
    br_redirect = 1'b0;
    check("t7_flushed", {31'd0, if_valid}, 32'd0);
    check("t7_addr_held", ic.addr, 32'h1C00_0304);
    accept();
    respond(32'hA000_0007);
    check("t7_addr", ic.addr, 32'h1C00_0400);

    // misaligned branch target
    br_redirect = 1'b1; br_target = 32'h1C00_0102;
    tick();
    br_redirect = 1'b0;
    accept();
    respond(32'hA000_0008);
`ifdef FETCH_ALIGN_CHK_EN
    check("t6_req", {31'd0, ic.req}, 32'd0);
    check("t6_valid", {31'd0, if_valid}, 32'd1);
    check("t6_adef", {31'd0, if_excp_adef}, 32'd1);
    check("t6_inst", if_inst, 32'h0340_0000);
    check("t6_pc", if_pc, 32'h1C00_0102);
    tick();
    check("t6_stay_req", {31'd0, ic.req}, 32'd0);
    check("t6_stay_valid", {31'd0, if_valid}, 32'd0);
    br_redirect = 1'b1; br_target = 32'h1C00_0500;
    tick();
    br_redirect = 1'b0;
    check("t6_exit_req", {31'd0, ic.req}, 32'd1);
    check("t6_exit_addr", ic.addr, 32'h1C00_0500);
`else
    check("t6_req", {31'd0, ic.req}, 32'd1);
    check("t6_masked_addr", ic.addr, 32'h1C00_0100);
`endif

    // PC+4 wraps
    br_redirect = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    br_redirect = 1'b0;
    accept();
    respond(32'hA000_0009);
    check("t8_addr", ic.addr, 32'hFFFF_FFFC);
    accept();
    respond(32'hA000_000A);
    check("t8_pc", if_pc, 32'hFFFF_FFFC);
    check("t8_wrap", ic.addr, 32'h0000_0000);

    // reset mid-transaction
    accept();
    rst = 1'b1;
    tick();
    check("t9_req", {31'd0, ic.req}, 32'd0);
    check("t9_addr", ic.addr, 32'h1C00_0000);
    check("t9_valid", {31'd0, if_valid}, 32'd0);
    rst = 1'b0;
    tick();
    check("t9_restart", {31'd0, ic.req}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
